// File: rtl/regfile_nrw.sv
// Parametrised two-read/one-write register file with rising-edge write detect,
// registered write-first read ports, per-register dirty map and a bulk-clear sweep.
module regfile_nrw #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int DIN_W    = 4,
  parameter bit PAD_ONES = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] W_Adr,
  input  logic [DIN_W-1:0]  Din,
  input  logic [ADDR_W-1:0] R_Adr,
  input  logic [ADDR_W-1:0] S_Adr,
  input  logic              clr,
  output logic [WIDTH-1:0]  R,
  output logic [WIDTH-1:0]  S,
  output logic              busy,
  output logic [DEPTH-1:0]  dirty
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic                we_q_r;
  logic [WIDTH-1:0]    mem_r [DEPTH];

  logic                wr_fire_s;
  logic                wr_en_s;
  logic                clr_en_s;
  logic                last_s;
  logic [WIDTH-1:0]    wdata_s;
  logic [WIDTH-1:0]    r_next_s;
  logic [WIDTH-1:0]    s_next_s;

  // Write/clear qualification; clear always wins over a coincident write edge
  always_comb begin
    wr_fire_s = we & ~we_q_r;
    wr_en_s   = wr_fire_s & (state_r == IDLE) & ~clr;
    clr_en_s  = (state_r == CLEAR);
    last_s    = (ptr_r == ADDR_W'(DEPTH - 1));
  end

  // Pad narrow input data up to the register width
  always_comb begin
    if (PAD_ONES) begin
      wdata_s = {WIDTH{1'b1}};
    end else begin
      wdata_s = {WIDTH{1'b0}};
    end
    wdata_s[DIN_W-1:0] = Din;
  end

  // Write-first read data for port R: same-edge clear or write overrides storage
  always_comb begin
    r_next_s = mem_r[R_Adr];
    if (clr_en_s && (ptr_r == R_Adr)) begin
      r_next_s = {WIDTH{1'b0}};
    end else if (wr_en_s && (W_Adr == R_Adr)) begin
      r_next_s = wdata_s;
    end else begin
      r_next_s = mem_r[R_Adr];
    end
  end

  // Write-first read data for port S
  always_comb begin
    s_next_s = mem_r[S_Adr];
    if (clr_en_s && (ptr_r == S_Adr)) begin
      s_next_s = {WIDTH{1'b0}};
    end else if (wr_en_s && (W_Adr == S_Adr)) begin
      s_next_s = wdata_s;
    end else begin
      s_next_s = mem_r[S_Adr];
    end
  end

  // Storage, dirty map, clear sweep FSM and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
      we_q_r  <= 1'b1;  // a level-high we across reset release must not write
      R       <= {WIDTH{1'b0}};
      S       <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      dirty   <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      we_q_r <= we;
      R      <= r_next_s;
      S      <= s_next_s;
      case (state_r)
        IDLE: begin
          if (clr) begin
            state_r <= CLEAR;
            busy    <= 1'b1;
            ptr_r   <= {ADDR_W{1'b0}};
          end else if (wr_fire_s) begin
            mem_r[W_Adr] <= wdata_s;
            dirty[W_Adr] <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          mem_r[ptr_r] <= {WIDTH{1'b0}};
          dirty[ptr_r] <= 1'b0;
          ptr_r        <= ptr_r + ADDR_W'(1);
          if (last_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
